// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory request, instruction register.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            IReqValid,
    input  logic            IReqReady,
    output logic [XLEN-1:0] IReqAddr,
    input  logic            IRespValid,
    input  logic [XLEN-1:0] IRespData,
    output logic            InstrValid,
    input  logic            InstrReady,
    output logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectPC,
    output logic            MisalignF
);

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_DROP = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_next;
    logic            pc_load;
    logic            instr_load;
    logic            req_fire;

    // A request is issued whenever S_REQ is presented and memory accepts it.
    assign req_fire = (state == S_REQ) && IReqReady;

    // Next-state, PC selection and instruction-register load enable.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        pc_load    = 1'b0;
        instr_load = 1'b0;

        if (Redirect) begin
            // Redirect wins over every other event; an issued but unanswered
            // request forces S_DROP so its response is never shown to decode.
            pc_load = 1'b1;
            pc_next = RedirectPC;
            case (state)
                S_REQ:   state_next = req_fire ? S_DROP : S_REQ;
                S_WAIT:  state_next = IRespValid ? S_REQ : S_DROP;
                // Still waiting on the stale response: keep discarding it.
                S_DROP:  state_next = IRespValid ? S_REQ : S_DROP;
                default: state_next = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (IReqReady) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (IRespValid) begin
                        instr_load = 1'b1;
                        state_next = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (InstrReady) begin
                        pc_load    = 1'b1;
                        pc_next    = PCSrc ? PCTarget : pc_plus4;
                        state_next = S_REQ;
                    end
                end
                S_DROP: begin
                    if (IRespValid) state_next = S_REQ;
                end
                S_HALT:  state_next = S_HALT;
                default: state_next = S_REQ;
            endcase
        end

        // Any misaligned PC that gets loaded parks the stage in S_HALT.
        if (pc_load && (pc_next[1:0] != 2'b00)) state_next = S_HALT;
    end

    // State, PC and instruction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            pc_plus4 <= RESET_PC + XLEN'(PC_STEP);
            instr    <= '0;
        end else begin
            state <= state_next;
            if (pc_load) begin
                pc       <= pc_next;
                pc_plus4 <= pc_next + XLEN'(PC_STEP);
            end
            if (instr_load) instr <= IRespData;
        end
    end

    // Handshake and status outputs decode straight from the state register.
    assign IReqValid  = (state == S_REQ) && !reset;
    assign InstrValid = (state == S_HOLD);
    assign MisalignF  = (state == S_HALT);
    assign IReqAddr   = pc;
    assign PCF        = pc;
    assign PCPlus4F   = pc_plus4;
    assign InstrF     = instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with an instruction scoreboard.
module tb_fetch_unit;

    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    logic        clk;
    logic        reset;
    logic        IReqValid;
    logic        IReqReady;
    logic [31:0] IReqAddr;
    logic        IRespValid;
    logic [31:0] IRespData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        MisalignF;

    int  n_checks = 0;
    int  n_fail   = 0;
    sb_t sb[$];

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .IReqValid  (IReqValid),
        .IReqReady  (IReqReady),
        .IReqAddr   (IReqAddr),
        .IRespValid (IRespValid),
        .IRespData  (IRespData),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .InstrF     (InstrF),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .MisalignF  (MisalignF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stale words must never be presented to decode.
    always @(negedge clk) begin
        if (InstrValid === 1'b1) begin
            n_checks++;
            assert (InstrF !== STALE) else begin
                n_fail++;
                $error("FAIL stale_shown: observed %h expected not %h", InstrF, STALE);
            end
        end
    end

    // One full fetch: request (optionally stalled), response after latency,
    // decode stall, then accept with the given PCSrc/PCTarget.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input int req_stall, input int resp_lat, input int dec_stall,
                            input logic src, input logic [31:0] tgt);
        sb_t e;
        int  waited;
        waited = 0;
        while (IReqValid !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        check("req_valid", IReqValid, 1'b1);
        check("req_addr", IReqAddr, addr);
        IReqReady = 1'b0;
        for (int i = 0; i < req_stall; i++) begin
            tick();
            check("req_hold_valid", IReqValid, 1'b1);
            check("req_hold_addr", IReqAddr, addr);
        end
        IReqReady = 1'b1;
        tick();
        IReqReady = 1'b0;
        sb.push_back('{pc: addr, instr: data});
        for (int i = 0; i < resp_lat; i++) begin
            check("wait_no_req", IReqValid, 1'b0);
            check("wait_no_instr", InstrValid, 1'b0);
            tick();
        end
        check("wait_no_req", IReqValid, 1'b0);
        IRespValid = 1'b1;
        IRespData  = data;
        tick();
        IRespValid = 1'b0;
        IRespData  = 32'h0;
        check("instr_valid", InstrValid, 1'b1);
        for (int i = 0; i < dec_stall; i++) begin
            InstrReady = 1'b0;
            tick();
            check("hold_valid", InstrValid, 1'b1);
            check("hold_instr", InstrF, data);
            check("hold_pc", PCF, addr);
            check("hold_no_req", IReqValid, 1'b0);
        end
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_instr", InstrF, e.instr);
            check("sb_pc", PCF, e.pc);
            check("sb_pc4", PCPlus4F, e.pc + 32'd4);
        end
        InstrReady = 1'b1;
        PCSrc      = src;
        PCTarget   = tgt;
        tick();
        InstrReady = 1'b0;
        PCSrc      = 1'b0;
        PCTarget   = 32'h0;
        check("after_accept_invalid", InstrValid, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        IReqReady  = 1'b0;
        IRespValid = 1'b0;
        IRespData  = 32'h0;
        InstrReady = 1'b0;
        PCSrc      = 1'b0;
        PCTarget   = 32'h0;
        Redirect   = 1'b0;
        RedirectPC = 32'h0;

        // Reset values
        repeat (2) tick();
        check("rst_req_valid", IReqValid, 1'b0);
        check("rst_pc", PCF, 32'h0);
        check("rst_pc4", PCPlus4F, 32'h4);
        check("rst_instr", InstrF, 32'h0);
        check("rst_instr_valid", InstrValid, 1'b0);
        check("rst_misalign", MisalignF, 1'b0);
        reset = 1'b0;
        #1;
        check("post_rst_req", IReqValid, 1'b1);

        // Basic fetch, then held decode with taken branch to 0x40
        do_fetch(32'h0000_0000, 32'h0050_0093, 0, 0, 0, 1'b0, 32'h0);
        check("next_addr_4", IReqAddr, 32'h4);
        do_fetch(32'h0000_0004, 32'h0010_0113, 0, 0, 5, 1'b1, 32'h40);
        check("next_addr_40", IReqAddr, 32'h40);
        do_fetch(32'h0000_0040, 32'h0020_0193, 0, 1, 0, 1'b1, 32'h8);

        // Request stalled three cycles, slow response
        do_fetch(32'h0000_0008, 32'h0030_0213, 3, 2, 0, 1'b0, 32'h0);

        // Redirect while waiting; stale response two cycles later is dropped
        check("c_req", IReqAddr, 32'hC);
        IReqReady = 1'b1;
        tick();
        IReqReady  = 1'b0;
        Redirect   = 1'b1;
        RedirectPC = 32'h100;
        tick();
        Redirect = 1'b0;
        check("redir_pc", PCF, 32'h100);
        check("redir_invalid", InstrValid, 1'b0);
        check("drop_no_req", IReqValid, 1'b0);
        tick();
        check("drop_no_req2", IReqValid, 1'b0);
        IRespValid = 1'b1;
        IRespData  = STALE;
        tick();
        IRespValid = 1'b0;
        check("drop_done_invalid", InstrValid, 1'b0);
        check("drop_done_req", IReqValid, 1'b1);
        check("drop_done_addr", IReqAddr, 32'h100);

        // Misaligned branch target halts; aligned redirect resumes
        do_fetch(32'h0000_0100, 32'h0040_0293, 0, 0, 0, 1'b1, 32'h102);
        check("halt_misalign", MisalignF, 1'b1);
        check("halt_pc", PCF, 32'h102);
        for (int i = 0; i < 3; i++) begin
            IReqReady = 1'b1;
            tick();
            check("halt_no_req", IReqValid, 1'b0);
            check("halt_sticky", MisalignF, 1'b1);
        end
        IReqReady  = 1'b0;
        Redirect   = 1'b1;
        RedirectPC = 32'h200;
        tick();
        Redirect = 1'b0;
        check("unhalt_misalign", MisalignF, 1'b0);
        check("unhalt_req", IReqValid, 1'b1);
        check("unhalt_addr", IReqAddr, 32'h200);

        // PC wrap at the top of the address space
        do_fetch(32'h0000_0200, 32'h0050_0313, 0, 0, 0, 1'b1, 32'hFFFF_FFFC);
        check("top_pc4", PCPlus4F, 32'h0);
        do_fetch(32'hFFFF_FFFC, 32'h0060_0393, 0, 0, 1, 1'b0, 32'h0);
        check("wrap_addr", IReqAddr, 32'h0);
        check("wrap_misalign", MisalignF, 1'b0);
        do_fetch(32'h0000_0000, 32'h0070_0413, 0, 0, 0, 1'b1, 32'h300);

        // Reset while waiting on a response
        check("pre_rst_addr", IReqAddr, 32'h300);
        IReqReady = 1'b1;
        tick();
        IReqReady = 1'b0;
        reset     = 1'b1;
        tick();
        check("midrst_pc", PCF, 32'h0);
        check("midrst_invalid", InstrValid, 1'b0);
        check("midrst_no_req", IReqValid, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_req", IReqValid, 1'b1);
        check("midrst_addr", IReqAddr, 32'h0);

        // Redirect in the same cycle a request is accepted forces a drop
        IReqReady  = 1'b1;
        Redirect   = 1'b1;
        RedirectPC = 32'h400;
        tick();
        IReqReady = 1'b0;
        Redirect  = 1'b0;
        check("hs_redir_pc", PCF, 32'h400);
        check("hs_redir_no_req", IReqValid, 1'b0);
        IRespValid = 1'b1;
        IRespData  = STALE;
        tick();
        IRespValid = 1'b0;
        check("hs_redir_req", IReqValid, 1'b1);
        check("hs_redir_addr", IReqAddr, 32'h400);
        check("hs_redir_invalid", InstrValid, 1'b0);
        do_fetch(32'h0000_0400, 32'h0080_0493, 0, 0, 0, 1'b0, 32'h0);
        check("final_addr", IReqAddr, 32'h404);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
